// File: rtl/hash_receiver.sv
//============================================================================
// Module      : hash_receiver
// Description : Receive side of the string-hash link. Reassembles an
//               MSB-first byte stream into a NUM_BYTES*8-bit hash, frames it
//               on the Z terminator, compares it against expectedHash and
//               reports Done / Match / Error.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module hash_receiver #(
  parameter int NUM_BYTES = 8,
  parameter int GAP_LIMIT = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [7:0]               Byte,
  input  logic                     ByteValid,
  input  logic                     Z,
  input  logic [8*NUM_BYTES-1:0]   expectedHash,
  output logic [8*NUM_BYTES-1:0]   hashValue,
  output logic [3:0]               byteCount,
  output logic                     Done,
  output logic                     Match,
  output logic                     Error
);

  localparam int          c_hw       = 8 * NUM_BYTES;
  localparam int          c_gw       = $clog2(GAP_LIMIT + 1);
  localparam logic [3:0]  c_num      = 4'(NUM_BYTES);
  localparam logic [c_gw-1:0] c_gap_last = c_gw'(GAP_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_gw-1:0] r_gap;
  logic            w_load;     // first byte of a new frame
  logic            w_shift;    // further in-frame byte accepted
  logic            w_gap_inc;  // idle cycle inside a frame

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath controls
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_gap_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ByteValid) begin
          w_load = 1'b1;
          if (Z) begin
            w_state_nxt = (NUM_BYTES == 1) ? S_CHECK : S_ERROR;
          end else begin
            w_state_nxt = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (ByteValid) begin
          if (byteCount == c_num) begin
            // Frame already full and a further byte arrived: long frame.
            w_state_nxt = S_ERROR;
          end else begin
            w_shift = 1'b1;
            if (Z) begin
              w_state_nxt = ((byteCount + 4'd1) == c_num) ? S_CHECK : S_ERROR;
            end
          end
        end else begin
          w_gap_inc = 1'b1;
          if (r_gap == c_gap_last) begin
            w_state_nxt = S_ERROR;
          end
        end
      end
      S_CHECK: w_state_nxt = S_IDLE;
      S_ERROR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Hash assembly, byte counter, gap timer and status flags
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hashValue <= '0;
      byteCount <= '0;
      Done      <= 1'b0;
      Match     <= 1'b0;
      Error     <= 1'b0;
      r_gap     <= '0;
    end else begin
      Done  <= (r_state == S_CHECK) || (r_state == S_ERROR);
      r_gap <= w_gap_inc ? (r_gap + 1'b1) : '0;
      if (w_load) begin
        hashValue <= c_hw'(Byte);
        byteCount <= 4'd1;
        Match     <= 1'b0;
        Error     <= 1'b0;
      end
      if (w_shift) begin
        hashValue <= (hashValue << 8) | c_hw'(Byte);
        byteCount <= byteCount + 4'd1;
      end
      if (r_state == S_CHECK) begin
        Match <= (hashValue == expectedHash);
      end
      if (r_state == S_ERROR) begin
        Error <= 1'b1;
        Match <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hash_receiver.sv
//============================================================================
// Module      : tb_hash_receiver
// Description : Self-checking bench for hash_receiver. Frames are described
//               as byte lists with idle gaps; a frame-level reference model
//               predicts the outcome, Done cycle and final outputs.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_hash_receiver;

  localparam int NB  = 8;
  localparam int GAP = 16;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  Byte = '0;
  logic        ByteValid = 1'b0;
  logic        Z = 1'b0;
  logic [63:0] expectedHash = '0;
  logic [63:0] hashValue;
  logic [3:0]  byteCount;
  logic        Done;
  logic        Match;
  logic        Error;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame description used by run_frame
  logic [7:0] fb[0:15];
  int         fg[0:15];   // idle cycles before byte i (i > 0)

  hash_receiver #(.NUM_BYTES(NB), .GAP_LIMIT(GAP)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Byte         (Byte),
    .ByteValid    (ByteValid),
    .Z            (Z),
    .expectedHash (expectedHash),
    .hashValue    (hashValue),
    .byteCount    (byteCount),
    .Done         (Done),
    .Match        (Match),
    .Error        (Error)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic load8(input logic [63:0] v);
    for (int i = 0; i < 8; i++) begin
      fb[i] = v[63 - 8*i -: 8];
      fg[i] = 0;
    end
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < 16; i++) fg[i] = 0;
  endtask

  // Drive one frame (entered just after a rising edge) and check it.
  task automatic run_frame(input string tag, input int nb, input bit zlast, input bit trail,
                           input bit use_own_hash, input logic [63:0] exp_in);
    int          t[0:15];
    int          cnt;
    int          dec;
    bit          decided;
    bit          good;
    logic [63:0] h;
    logic [63:0] exp_val;
    bit          hit;
    t[0] = 0;
    for (int i = 1; i < nb; i++) t[i] = t[i-1] + 1 + fg[i];
    // Reference: walk the frame with the receive rules
    cnt = 0; h = '0; decided = 0; good = 0; dec = 0;
    for (int i = 0; i < nb; i++) begin
      if (!decided) begin
        if (cnt == NB) begin
          decided = 1; good = 0; dec = t[i];
        end else begin
          h = (h << 8) | 64'(fb[i]);
          cnt++;
          if (zlast && i == nb - 1) begin
            decided = 1; good = (cnt == NB); dec = t[i];
          end
        end
      end
    end
    if (!decided) begin
      dec  = t[nb-1] + GAP;
      good = 0;
    end
    exp_val = use_own_hash ? h : exp_in;
    for (int c = 0; c <= dec + 2; c++) begin
      hit = 0;
      ByteValid = 1'b0; Z = 1'b0; Byte = 8'($urandom);
      for (int i = 0; i < nb; i++) begin
        if (t[i] == c) begin
          hit = 1; ByteValid = 1'b1; Byte = fb[i]; Z = zlast && (i == nb - 1);
        end
      end
      if (trail && !hit && c == t[nb-1] + 1) begin
        ByteValid = 1'b1; Byte = 8'($urandom); Z = 1'b1;
      end
      expectedHash = (c == dec + 1) ? exp_val : {$urandom, $urandom};
      @(negedge Clock);
      if (Done !== (c == dec + 2)) check_eq({tag, " done"}, 64'(Done), 64'(c == dec + 2));
      else n_checks++;
      @(posedge Clock); #1;
    end
    ByteValid = 1'b0; Z = 1'b0;
    check_eq({tag, " done_low"},  64'(Done), 64'd0);
    check_eq({tag, " hash"},      hashValue, h);
    check_eq({tag, " count"},     64'(byteCount), 64'(cnt));
    check_eq({tag, " match"},     64'(Match), 64'(good && (h == exp_val)));
    check_eq({tag, " error"},     64'(Error), 64'(!good));
  endtask

  // Assert Reset between edges and check that outputs clear without a clock edge.
  task automatic async_reset_check(input string tag);
    ByteValid = 1'b0; Z = 1'b0;
    #3 Reset = 1'b1;
    #1;
    check_eq({tag, " hash"},  hashValue, 64'd0);
    check_eq({tag, " count"}, 64'(byteCount), 64'd0);
    check_eq({tag, " done"},  64'(Done), 64'd0);
    check_eq({tag, " match"}, 64'(Match), 64'd0);
    check_eq({tag, " error"}, 64'(Error), 64'd0);
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int nb;
    #70;
    check_eq("rst hash",  hashValue, 64'd0);
    check_eq("rst count", 64'(byteCount), 64'd0);
    check_eq("rst done",  64'(Done), 64'd0);
    check_eq("rst match", 64'(Match), 64'd0);
    check_eq("rst error", 64'(Error), 64'd0);
    #10 Reset = 1'b0;
    @(posedge Clock); #1;

    load8(64'h0000_0652_A553_28CA);
    run_frame("frameA", 8, 1, 0, 0, 64'h652a55328ca);
    load8(64'h0000_D0AB_8903_9614);
    run_frame("frameB", 8, 1, 0, 0, 64'hd0a7798b0879);
    load8({$urandom, $urandom});
    run_frame("short5", 5, 1, 0, 1, 64'd0);
    load8({$urandom, $urandom});
    run_frame("good_after_short", 8, 1, 0, 1, 64'd0);
    load8({$urandom, $urandom});
    run_frame("timeout3", 3, 0, 0, 1, 64'd0);
    load8({$urandom, $urandom});
    run_frame("good_after_timeout", 8, 1, 0, 1, 64'd0);
    // Match is high here; reset must clear it asynchronously
    async_reset_check("rst_idle");

    for (int i = 0; i < 4; i++) begin
      ByteValid = 1'b1; Byte = 8'(8'hA0 + i); Z = 1'b0;
      @(posedge Clock); #1;
    end
    ByteValid = 1'b0;
    check_eq("midframe count", 64'(byteCount), 64'd4);
    async_reset_check("rst_midframe");
    load8({$urandom, $urandom});
    run_frame("good_after_reset", 8, 1, 0, 1, 64'd0);

    load8({$urandom, $urandom});
    fb[8] = 8'($urandom); fg[8] = 0;
    run_frame("long9", 9, 1, 1, 1, 64'd0);

    // Gap of GAP_LIMIT-1 inside a frame must not abort it
    load8({$urandom, $urandom});
    fg[4] = GAP - 1;
    run_frame("gap_edge", 8, 1, 0, 1, 64'd0);

    for (int f = 0; f < 40; f++) begin
      load8({$urandom, $urandom});
      fb[8] = 8'($urandom);
      clear_gaps();
      for (int i = 1; i < 9; i++) fg[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, GAP - 1) : 0;
      kind = $urandom_range(0, 3);
      case (kind)
        0: run_frame("rnd_good", 8, 1, 0, $urandom_range(0, 1) == 1, {$urandom, $urandom});
        1: begin
          nb = $urandom_range(1, NB - 1);
          run_frame("rnd_short", nb, 1, 0, 1, 64'd0);
        end
        2: begin
          nb = $urandom_range(1, NB);
          run_frame("rnd_timeout", nb, 0, 0, 1, 64'd0);
        end
        default: begin
          fg[8] = 0;
          run_frame("rnd_long", 9, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, 64'd0);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
